sift_sched: RTL and testbench

SIFT_SCHED -- requirements
Module: sift_sched

---
 rtl/sift_pkg.sv | 21 ++
 rtl/sift_sat_cnt.sv | 29 ++
 rtl/sift_sched.sv | 155 +++++++++++++++
 tb/tb_sift_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_pkg.sv
// Shared constants and FSM state type for the SIFT frame scheduler.
package sift_pkg;

    localparam int unsigned ROWS      = 480;
    localparam int unsigned COLS      = 640;
    localparam int unsigned KPT_DEPTH = 2000;
    localparam int unsigned ROW_W     = 9;
    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned ENGINES   = 4;
    localparam int unsigned LAYERS    = 2;

    typedef enum logic [2:0] {
        StIdle,
        StBlurIssue,
        StBlurWait,
        StDetIssue,
        StDetWait,
        StDone
    } state_e;

endpackage

// File: rtl/sift_sat_cnt.sv
// Saturating up-counter with synchronous clear; sat is high while the count equals LIMIT.
module sift_sat_cnt #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned LIMIT = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    logic [WIDTH-1:0] count_q;

    assign sat   = (count_q == WIDTH'(LIMIT));
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && !sat) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/sift_sched.sv
// Frame scheduler: issues blur rows, waits for all engines, issues detect rows,
// and allocates keypoint memory addresses per layer with overflow tracking.
module sift_sched #(
    parameter int unsigned ROWS      = 480,
    parameter int unsigned DET_FIRST = 1,
    parameter int unsigned DET_LAST  = 478,
    parameter int unsigned KPT_DEPTH = 2000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    input  logic                                blur_ready,
    output logic                                blur_issue,
    output logic [sift_pkg::ROW_W-1:0]          blur_row,
    input  logic [sift_pkg::ENGINES-1:0]        blur_row_done,
    output logic [sift_pkg::ENGINES-1:0]        gaussian_done,
    input  logic                                det_ready,
    output logic                                det_issue,
    output logic [sift_pkg::ROW_W-1:0]          det_row,
    input  logic                                det_row_done,
    input  logic [sift_pkg::LAYERS-1:0]         kpt_valid,
    output logic [sift_pkg::LAYERS-1:0]         kpt_wr_en,
    output logic [sift_pkg::ADDR_W-1:0]         kpt_addr_1,
    output logic [sift_pkg::ADDR_W-1:0]         kpt_addr_2,
    output logic [sift_pkg::LAYERS-1:0]         kpt_ovf,
    output logic                                detect_filter_done,
    output logic                                busy
);

    import sift_pkg::*;

    localparam int unsigned DET_ROWS = DET_LAST - DET_FIRST + 1;
    localparam int unsigned AW1      = ADDR_W + 1;

    state_e state_q, state_d;
    logic   start;

    logic [ROW_W-1:0]   blur_next_q, blur_row_q, det_next_q, det_row_q;
    logic               blur_issue_q, det_issue_q, done_q, busy_q;
    logic [ENGINES-1:0] gd_q, blur_sat;
    logic [ROW_W-1:0]   blur_cnt [ENGINES];
    logic [ROW_W-1:0]   det_cnt;
    logic               det_sat;
    logic [LAYERS-1:0]  kpt_wr_q, kpt_ovf_q, kpt_room, kpt_sat;
    logic [ADDR_W-1:0]  kpt_cnt [LAYERS];
    logic               unused_cnt;

    assign start = (state_q == StIdle) && in_valid;

    for (genvar i = 0; i < ENGINES; i++) begin : g_blur
        sift_sat_cnt #(.WIDTH(ROW_W), .LIMIT(ROWS)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (start),
            .inc   (blur_row_done[i]),
            .count (blur_cnt[i]),
            .sat   (blur_sat[i])
        );
    end

    sift_sat_cnt #(.WIDTH(ROW_W), .LIMIT(DET_ROWS)) u_det_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .inc   (det_row_done),
        .count (det_cnt),
        .sat   (det_sat)
    );

    // The counter is the address on the port; a strobe already presented still
    // advances it at the next edge, so room must account for that pending write.
    for (genvar k = 0; k < LAYERS; k++) begin : g_kpt
        sift_sat_cnt #(.WIDTH(ADDR_W), .LIMIT(KPT_DEPTH)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (start),
            .inc   (kpt_wr_q[k]),
            .count (kpt_cnt[k]),
            .sat   (kpt_sat[k])
        );
        assign kpt_room[k] = start ||
            ((AW1'(kpt_cnt[k]) + AW1'(kpt_wr_q[k])) < AW1'(KPT_DEPTH));
    end

    assign unused_cnt = ^{blur_cnt[0], blur_cnt[1], blur_cnt[2], blur_cnt[3], det_cnt, kpt_sat};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (in_valid) state_d = StBlurIssue;
            StBlurIssue: if (blur_ready && blur_next_q == ROW_W'(ROWS - 1)) state_d = StBlurWait;
            StBlurWait:  if (&gd_q) state_d = StDetIssue;
            StDetIssue:  if (det_ready && det_next_q == ROW_W'(DET_LAST)) state_d = StDetWait;
            StDetWait:   if (det_sat) state_d = StDone;
            StDone:      if (!in_valid) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            blur_next_q  <= '0;
            blur_row_q   <= '0;
            det_next_q   <= '0;
            det_row_q    <= '0;
            blur_issue_q <= 1'b0;
            det_issue_q  <= 1'b0;
            gd_q         <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            kpt_wr_q     <= '0;
            kpt_ovf_q    <= '0;
        end else begin
            state_q      <= state_d;
            blur_issue_q <= (state_q == StBlurIssue) && blur_ready;
            det_issue_q  <= (state_q == StDetIssue) && det_ready;
            done_q       <= (state_d == StDone);
            busy_q       <= (state_d != StIdle) && (state_d != StDone);
            kpt_wr_q     <= kpt_valid & kpt_room;
            if (start) begin
                blur_next_q <= '0;
                blur_row_q  <= '0;
                det_next_q  <= ROW_W'(DET_FIRST);
                det_row_q   <= '0;
                gd_q        <= '0;
                kpt_ovf_q   <= '0;
            end else begin
                if (state_q == StBlurIssue && blur_ready) begin
                    blur_row_q  <= blur_next_q;
                    blur_next_q <= blur_next_q + 1'b1;
                end
                if (state_q == StDetIssue && det_ready) begin
                    det_row_q  <= det_next_q;
                    det_next_q <= det_next_q + 1'b1;
                end
                gd_q      <= gd_q | blur_sat;
                kpt_ovf_q <= kpt_ovf_q | (kpt_valid & ~kpt_room);
            end
        end
    end

    assign blur_issue         = blur_issue_q;
    assign blur_row           = blur_row_q;
    assign gaussian_done      = gd_q;
    assign det_issue          = det_issue_q;
    assign det_row            = det_row_q;
    assign kpt_wr_en          = kpt_wr_q;
    assign kpt_addr_1         = kpt_cnt[0];
    assign kpt_addr_2         = kpt_cnt[1];
    assign kpt_ovf            = kpt_ovf_q;
    assign detect_filter_done = done_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_sift_sched.sv
// Randomized bench for sift_sched: frame-level reference model checked every cycle,
// plus literal end-of-scenario expectations.
module tb_sift_sched;

    localparam int ROWS      = 480;
    localparam int DET_FIRST = 1;
    localparam int DET_LAST  = 478;
    localparam int KPT_DEPTH = 2000;
    localparam int NDET      = DET_LAST - DET_FIRST + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       blur_ready = 1'b0;
    logic       det_ready = 1'b0;
    logic       det_row_done = 1'b0;
    logic [3:0] blur_row_done = '0;
    logic [1:0] kpt_valid = '0;

    logic        blur_issue, det_issue, detect_filter_done, busy;
    logic [8:0]  blur_row, det_row;
    logic [3:0]  gaussian_done;
    logic [1:0]  kpt_wr_en, kpt_ovf;
    logic [10:0] kpt_addr_1, kpt_addr_2;

    sift_sched dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .blur_ready         (blur_ready),
        .blur_issue         (blur_issue),
        .blur_row           (blur_row),
        .blur_row_done      (blur_row_done),
        .gaussian_done      (gaussian_done),
        .det_ready          (det_ready),
        .det_issue          (det_issue),
        .det_row            (det_row),
        .det_row_done       (det_row_done),
        .kpt_valid          (kpt_valid),
        .kpt_wr_en          (kpt_wr_en),
        .kpt_addr_1         (kpt_addr_1),
        .kpt_addr_2         (kpt_addr_2),
        .kpt_ovf            (kpt_ovf),
        .detect_filter_done (detect_filter_done),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level reference model
    typedef enum int {PIdle, PBlur, PBWait, PDet, PDWait, PDone} phase_e;
    phase_e     ph = PIdle;
    int         nb = 0, nd = 0, dcnt = 0;
    int         bcnt [4];
    int         acc [2];
    logic [3:0] e_gd = '0;
    logic [1:0] e_ovf = '0, e_wr = '0;
    int         e_addr [2];
    int         e_brow = 0, e_drow = 0;
    bit         e_bi = 0, e_di = 0, e_done = 0, e_busy = 0;

    // Stimulus controls
    bit         tog_mode = 0, det_rand = 0, slow2 = 0;
    int         kpt_mode = 0;
    logic [1:0] kpt_force = '0;
    int         bq [4][$];
    int         dq [$];

    // Observations for literal checks
    int n_bi = 0, first_brow = -1, last_brow = -1;
    int n_di = 0, first_drow = -1, last_drow = -1;
    int n_wr0 = 0, n_wr1 = 0, last_wa0 = -1;
    bit saw_1011 = 0;

    task step_model();
        bit start;
        if (!rst_n) begin
            ph = PIdle; nb = 0; nd = 0; dcnt = 0;
            for (int i = 0; i < 4; i++) bcnt[i] = 0;
            for (int k = 0; k < 2; k++) begin acc[k] = 0; e_addr[k] = 0; end
            e_gd = '0; e_ovf = '0; e_wr = '0; e_brow = 0; e_drow = 0;
            e_bi = 0; e_di = 0; e_done = 0; e_busy = 0;
        end else begin
            start = (ph == PIdle) && in_valid;
            e_bi = 0;
            e_di = 0;
            case (ph)
                PIdle:  if (in_valid) ph = PBlur;
                PBlur:  if (blur_ready) begin
                            e_bi = 1; e_brow = nb; nb++;
                            if (nb == ROWS) ph = PBWait;
                        end
                PBWait: if (e_gd == 4'hF) ph = PDet;
                PDet:   if (det_ready) begin
                            e_di = 1; e_drow = DET_FIRST + nd; nd++;
                            if (nd == NDET) ph = PDWait;
                        end
                PDWait: if (dcnt == NDET) ph = PDone;
                PDone:  if (!in_valid) ph = PIdle;
                default: ph = PIdle;
            endcase
            if (start) begin
                nb = 0; nd = 0; dcnt = 0; e_brow = 0; e_drow = 0; e_gd = '0; e_ovf = '0;
                for (int i = 0; i < 4; i++) bcnt[i] = 0;
                for (int k = 0; k < 2; k++) acc[k] = 0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (bcnt[i] == ROWS) e_gd[i] = 1'b1;
                    if (blur_row_done[i] && bcnt[i] < ROWS) bcnt[i]++;
                end
                if (det_row_done && dcnt < NDET) dcnt++;
            end
            for (int k = 0; k < 2; k++) begin
                e_wr[k]   = kpt_valid[k] && (acc[k] < KPT_DEPTH);
                e_addr[k] = acc[k];
                if (e_wr[k]) acc[k]++;
                else if (kpt_valid[k]) e_ovf[k] = 1'b1;
            end
            e_done = (ph == PDone);
            e_busy = (ph != PIdle) && (ph != PDone);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        step_model();
        #1;
        check("blur_issue", int'(blur_issue), int'(e_bi));
        check("blur_row", int'(blur_row), e_brow);
        check("gaussian_done", int'(gaussian_done), int'(e_gd));
        check("det_issue", int'(det_issue), int'(e_di));
        check("det_row", int'(det_row), e_drow);
        check("kpt_wr_en", int'(kpt_wr_en), int'(e_wr));
        check("kpt_addr_1", int'(kpt_addr_1), e_addr[0]);
        check("kpt_addr_2", int'(kpt_addr_2), e_addr[1]);
        check("kpt_ovf", int'(kpt_ovf), int'(e_ovf));
        check("detect_filter_done", int'(detect_filter_done), int'(e_done));
        check("busy", int'(busy), int'(e_busy));
        if (blur_issue) begin
            if (n_bi == 0) first_brow = int'(blur_row);
            last_brow = int'(blur_row);
            n_bi++;
            for (int i = 0; i < 4; i++) bq[i].push_back(cyc + 3 + ((slow2 && i == 2) ? 60 : 0));
        end
        if (det_issue) begin
            if (n_di == 0) first_drow = int'(det_row);
            last_drow = int'(det_row);
            n_di++;
            dq.push_back(cyc + 2);
        end
        if (gaussian_done == 4'b1011) saw_1011 = 1;
        if (kpt_wr_en[0]) begin n_wr0++; last_wa0 = int'(kpt_addr_1); end
        if (kpt_wr_en[1]) n_wr1++;
    end

    always @(negedge clk) begin
        blur_ready = tog_mode ? ~blur_ready : 1'b1;
        det_ready  = det_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        for (int i = 0; i < 4; i++) begin
            blur_row_done[i] = 1'b0;
            if (bq[i].size() > 0 && bq[i][0] <= cyc) begin
                blur_row_done[i] = 1'b1;
                void'(bq[i].pop_front());
            end
        end
        det_row_done = 1'b0;
        if (dq.size() > 0 && dq[0] <= cyc) begin
            det_row_done = 1'b1;
            void'(dq.pop_front());
        end
        case (kpt_mode)
            0:       kpt_valid = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            1:       kpt_valid = kpt_force;
            default: kpt_valid = 2'b00;
        endcase
    end

    task automatic clear_obs();
        n_bi = 0; first_brow = -1; last_brow = -1;
        n_di = 0; first_drow = -1; last_drow = -1;
        n_wr0 = 0; n_wr1 = 0; last_wa0 = -1; saw_1011 = 0;
    endtask

    task automatic pulse_start();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!detect_filter_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!detect_filter_done) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_kpt_addr_1", int'(kpt_addr_1), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_blur_issue", int'(blur_issue), 0);
        check("post_rst_done", int'(detect_filter_done), 0);

        // Frame A: always ready, 3-cycle engine echo
        clear_obs();
        pulse_start();
        wait_done("frame_a", 5000);
        check("a_blur_issues", n_bi, 480);
        check("a_first_blur_row", first_brow, 0);
        check("a_last_blur_row", last_brow, 479);
        check("a_det_issues", n_di, 478);
        check("a_first_det_row", first_drow, 1);
        check("a_last_det_row", last_drow, 478);
        check("a_gaussian_done", int'(gaussian_done), 15);
        repeat (2) @(negedge clk);

        // Frame B: toggled blur_ready, random det_ready, engine 2 late by 60 cycles
        tog_mode = 1; det_rand = 1; slow2 = 1;
        clear_obs();
        pulse_start();
        for (int n = 0; n < 3000 && n_bi < 480; n++) @(negedge clk);
        check("b_blur_issues", n_bi, 480);
        check("b_last_blur_row", last_brow, 479);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("b_gd_partial", int'(gaussian_done), 11);
        check("b_no_det_yet", n_di, 0);
        wait_done("frame_b", 5000);
        check("b_saw_1011", int'(saw_1011), 1);
        check("b_det_issues", n_di, 478);
        in_valid = 1'b1;
        repeat (50) @(negedge clk);
        check("b_hold_done", int'(detect_filter_done), 1);
        check("b_no_second_frame", n_bi, 480);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("b_back_idle", int'(detect_filter_done), 0);
        tog_mode = 0; det_rand = 0; slow2 = 0;

        // Frame C: layer 1 requests 2005 cycles in a row from the start edge
        kpt_mode = 2;
        repeat (3) @(negedge clk);
        clear_obs();
        kpt_force = 2'b01;
        kpt_mode  = 1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2004) @(negedge clk);
        kpt_mode = 2;
        repeat (3) @(negedge clk);
        check("c_writes_l1", n_wr0, 2000);
        check("c_last_addr_l1", last_wa0, 1999);
        check("c_kpt_addr_1", int'(kpt_addr_1), 2000);
        check("c_kpt_ovf", int'(kpt_ovf), 1);
        check("c_writes_l2", n_wr1, 0);
        check("c_kpt_addr_2", int'(kpt_addr_2), 0);
        kpt_mode = 0;
        repeat (5) @(negedge clk);

        // Frame D: reset in the middle of detect issue, then restart
        det_rand = 1;
        clear_obs();
        pulse_start();
        begin
            int n = 0;
            while (!(det_issue && det_row == 9'd200) && n < 5000) begin
                @(negedge clk);
                n++;
            end
            if (!(det_issue && det_row == 9'd200)) check("d_reach_row200_timeout", 0, 1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("d_rst_busy", int'(busy), 0);
        check("d_rst_det_issue", int'(det_issue), 0);
        check("d_rst_det_row", int'(det_row), 0);
        check("d_rst_blur_row", int'(blur_row), 0);
        check("d_rst_gd", int'(gaussian_done), 0);
        check("d_rst_kpt_wr", int'(kpt_wr_en), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) bq[i].delete();
        dq.delete();
        repeat (2) @(negedge clk);
        clear_obs();
        pulse_start();
        for (int n = 0; n < 100 && n_bi == 0; n++) @(negedge clk);
        check("d_restart_first_row", first_brow, 0);
        wait_done("frame_d", 5000);
        check("d_det_issues", n_di, 478);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
